// File: rtl/lsfr_pair_pkg.sv
// Shared constants for the snake-game random source.
// Holds register widths and feedback tap masks for lsfr5 / lsfr6.
package lsfr_pair_pkg;

    localparam int LSFR5_W = 5;
    localparam int LSFR6_W = 6;

    // Bit k set means q[k] takes part in the XNOR feedback.
    localparam logic [LSFR5_W-1:0] LSFR5_TAPS = 5'b10100;
    localparam logic [LSFR6_W-1:0] LSFR6_TAPS = 6'b110000;

    typedef logic [LSFR5_W-1:0] q5_t;
    typedef logic [LSFR6_W-1:0] q6_t;

endpackage

// File: rtl/lsfr_pair_if.sv
// Bundle carrying both pseudo-random values to the apple spawner.
// master: drives q5/q6 (lsfr_pair); slave: reads them (spawner).
interface lsfr_pair_if;
    import lsfr_pair_pkg::*;

    q5_t q5;
    q6_t q6;

    modport master (output q5, output q6);
    modport slave  (input  q5, input  q6);

endinterface

// File: rtl/lfsr_core.sv
// Generic Fibonacci LFSR with XNOR feedback, shifting left each clock.
// Ports: clk, reset (sync, active-high), q (state, straight from flops).
module lfsr_core #(
    parameter int               WIDTH = 5,
    parameter logic [WIDTH-1:0] TAPS  = 5'b10100
) (
    input  logic             clk,
    input  logic             reset,
    output logic [WIDTH-1:0] q
);

    logic fb;

    // XNOR form: all-zeros is a legal state, all-ones is the lock-up.
    assign fb = ~^(q & TAPS);

    always_ff @(posedge clk) begin
        if (reset) begin
            q <= '0;
        end else begin
            q <= {q[WIDTH-2:0], fb};
        end
    end

    no_lockup: assert property (
        @(posedge clk) disable iff (reset) !(&q)
    );

endmodule

// File: rtl/lsfr5.sv
// 5-bit maximal-length LFSR, x^5+x^3+1, period 31.
// Ports (positional order fixed): clk, reset, q[4:0].
module lsfr5
    import lsfr_pair_pkg::*;
(
    input  logic clk,
    input  logic reset,
    output q5_t  q
);

    lfsr_core #(
        .WIDTH (LSFR5_W),
        .TAPS  (LSFR5_TAPS)
    ) u_core (
        .clk   (clk),
        .reset (reset),
        .q     (q)
    );

endmodule

// File: rtl/lsfr6.sv
// 6-bit maximal-length LFSR, x^6+x^5+1, period 63.
// Ports (positional order fixed): clk, reset, q[5:0].
module lsfr6
    import lsfr_pair_pkg::*;
(
    input  logic clk,
    input  logic reset,
    output q6_t  q
);

    lfsr_core #(
        .WIDTH (LSFR6_W),
        .TAPS  (LSFR6_TAPS)
    ) u_core (
        .clk   (clk),
        .reset (reset),
        .q     (q)
    );

endmodule

// File: rtl/lsfr_pair.sv
// Pair of free-running LFSRs feeding the apple spawner row/column pick.
// Ports: clk, reset (sync, active-high), rnd (master: q5, q6).
module lsfr_pair
    import lsfr_pair_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    lsfr_pair_if.master  rnd
);

    q5_t q5_w;
    q6_t q6_w;

    lsfr5 u_lsfr5 (clk, reset, q5_w);
    lsfr6 u_lsfr6 (clk, reset, q6_w);

    assign rnd.q5 = q5_w;
    assign rnd.q6 = q6_w;

endmodule

// File: tb/tb_lsfr_pair.sv
// Self-checking bench for lsfr_pair: bit-stream model plus directed
// sequence, period, reset and residue-coverage checks.
module tb_lsfr_pair;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    lsfr_pair_if rnd ();

    lsfr_pair dut (
        .clk   (clk),
        .reset (reset),
        .rnd   (rnd)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Model: each register is a window onto an output bit stream
    // s[n] = ~(s[n-a] ^ s[n-b]), with bits before the stream start = 0.
    bit   s5[$];
    bit   s6[$];
    bit   mvalid;
    logic [4:0] exp5;
    logic [5:0] exp6;

    function automatic bit sb(input bit six, input int i);
        if (i < 0) return 1'b0;
        return six ? s6[i] : s5[i];
    endfunction

    initial begin
        mvalid = 1'b0;
        exp5   = '0;
        exp6   = '0;
    end

    always @(posedge clk) begin
        int n5;
        int n6;
        if (reset) begin
            s5.delete();
            s6.delete();
            mvalid = 1'b1;
        end else if (mvalid) begin
            n5 = s5.size();
            n6 = s6.size();
            s5.push_back(~(sb(1'b0, n5 - 5) ^ sb(1'b0, n5 - 3)));
            s6.push_back(~(sb(1'b1, n6 - 6) ^ sb(1'b1, n6 - 5)));
        end
        n5 = s5.size();
        n6 = s6.size();
        for (int k = 0; k < 5; k++) exp5[k] = sb(1'b0, n5 - 1 - k);
        for (int k = 0; k < 6; k++) exp6[k] = sb(1'b1, n6 - 1 - k);
    end

    always @(negedge clk) begin
        if (mvalid) begin
            chk("model_q5", 32'(rnd.q5), 32'(exp5));
            chk("model_q6", 32'(rnd.q6), 32'(exp6));
        end
    end

    int lit5 [7] = '{0, 1, 3, 7, 14, 28, 25};
    int lit6 [8] = '{0, 1, 3, 7, 15, 31, 62, 61};

    task automatic pulse_reset(input int len);
        reset = 1'b1;
        repeat (len) @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        bit         seen5 [32];
        bit         seen6 [64];
        int         first0_5;
        int         first0_6;
        int         dist5;
        int         dist6;
        logic [15:0] r5;
        logic [15:0] r6;

        checks = 0;
        errors = 0;
        reset  = 1'b1;

        // Reset then run: literal sequences pin both DUT and model.
        repeat (2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            if (i < 7) begin
                chk("seq5", 32'(rnd.q5), 32'(lit5[i]));
                chk("pin5", 32'(exp5), 32'(lit5[i]));
            end
            chk("seq6", 32'(rnd.q6), 32'(lit6[i]));
            chk("pin6", 32'(exp6), 32'(lit6[i]));
            reset = 1'b0;
            @(negedge clk);
        end

        // Period and coverage.
        pulse_reset(1);
        first0_5 = -1;
        first0_6 = -1;
        for (int c = 0; c <= 63; c++) begin
            if (c > 0 && first0_5 < 0 && rnd.q5 == 5'd0) first0_5 = c;
            if (c > 0 && first0_6 < 0 && rnd.q6 == 6'd0) first0_6 = c;
            if (c < 31) seen5[rnd.q5] = 1'b1;
            if (c < 63) seen6[rnd.q6] = 1'b1;
            if (c < 63) @(negedge clk);
        end
        dist5 = 0;
        dist6 = 0;
        foreach (seen5[i]) dist5 += int'(seen5[i]);
        foreach (seen6[i]) dist6 += int'(seen6[i]);
        chk("period5", 32'(first0_5), 32'd31);
        chk("period6", 32'(first0_6), 32'd63);
        chk("distinct5", 32'(dist5), 32'd31);
        chk("distinct6", 32'(dist6), 32'd63);
        chk("no_ones5", 32'(seen5[31]), 32'd0);
        chk("no_ones6", 32'(seen6[63]), 32'd0);

        // Reset mid-operation at cycle 10 for 3 cycles.
        pulse_reset(1);
        repeat (10) @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("mid_rst5", 32'(rnd.q5), 32'd0);
            chk("mid_rst6", 32'(rnd.q6), 32'd0);
        end
        reset = 1'b0;
        @(negedge clk);
        chk("resume5", 32'(rnd.q5), 32'd1);
        chk("resume6", 32'(rnd.q6), 32'd1);

        // Reset held 5 cycles from an arbitrary state.
        repeat ($urandom_range(5, 60)) @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold5", 32'(rnd.q5), 32'd0);
            chk("hold6", 32'(rnd.q6), 32'd0);
        end
        reset = 1'b0;

        // Spawner residues over 200 cycles.
        r5 = '0;
        r6 = '0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            r5[rnd.q5[3:0]] = 1'b1;
            r6[rnd.q6[3:0]] = 1'b1;
        end
        chk("resid5", 32'(r5), 32'hFFFF);
        chk("resid6", 32'(r6), 32'hFFFF);

        // Random runs with random reset pulses; the model checks each cycle.
        for (int r = 0; r < 30; r++) begin
            repeat ($urandom_range(1, 90)) @(negedge clk);
            pulse_reset($urandom_range(1, 4));
        end
        repeat (20) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
